// File: rtl/jts16_mem_bridge_pkg.sv
// Purpose : shared types, FSM encoding and default SDRAM bases for the jts16 memory bridge.
// Latency : n/a (declarations only).
// Backpressure: n/a.
package jts16_mem_bridge_pkg;

    localparam int ROM_AW = 17;
    localparam int CPU_AW = 13;
    localparam int DW     = 16;
    localparam int SD_AW  = 22;

    typedef logic [SD_AW-1:0]  sdram_addr_t;
    typedef logic [ROM_AW-1:0] rom_addr_t;
    typedef logic [CPU_AW-1:0] cpu_addr_t;
    typedef logic [DW-1:0]     data_t;

    // Default SDRAM word bases of the three regions.
    localparam sdram_addr_t ROM_OFFSET_DEF  = 22'h00_0000;
    localparam sdram_addr_t RAM_OFFSET_DEF  = 22'h10_0000;
    localparam sdram_addr_t VRAM_OFFSET_DEF = 22'h10_4000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    // Which requester owns the transaction in flight.
    typedef enum logic [1:0] {
        SRC_ROM  = 2'd0,
        SRC_RAM  = 2'd1,
        SRC_VRAM = 2'd2
    } src_t;

    // Region base plus word offset; wraps modulo 2^22 by construction.
    function automatic sdram_addr_t sd_addr(input sdram_addr_t base, input sdram_addr_t off);
        return base + off;
    endfunction

endpackage

// File: rtl/jts16_mem_bridge_if.sv
// Purpose : SDRAM request/response bus between the bridge (master) and the SDRAM controller (slave).
// Latency : n/a (wiring only).
// Backpressure: request is held by the master until the slave pulses sdram_ack.
interface jts16_mem_bridge_if;

    logic                                    sdram_req;
    jts16_mem_bridge_pkg::sdram_addr_t       sdram_addr;
    logic                                    sdram_we;
    logic [1:0]                              sdram_dsn;
    jts16_mem_bridge_pkg::data_t             sdram_din;
    logic                                    sdram_ack;
    logic                                    sdram_rdy;
    jts16_mem_bridge_pkg::data_t             sdram_dout;

    modport master (
        output sdram_req, sdram_addr, sdram_we, sdram_dsn, sdram_din,
        input  sdram_ack, sdram_rdy, sdram_dout
    );

    modport slave (
        input  sdram_req, sdram_addr, sdram_we, sdram_dsn, sdram_din,
        output sdram_ack, sdram_rdy, sdram_dout
    );

endinterface

// File: rtl/jts16_rom_cache.sv
// Purpose : one-entry ROM read cache (tag/data/valid) with combinational hit compare.
// Latency : hit reported in the same cycle as rom_cs; fill visible the cycle after the fill edge.
// Backpressure: none; fill is a single-cycle write strobe from the bridge FSM.
// Ports   : clk/rst; fill/fill_tag/fill_data load the entry; rom_cs/rom_addr look up; rom_ok/rom_data answer.
module jts16_rom_cache
    import jts16_mem_bridge_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      fill,
    input  rom_addr_t fill_tag,
    input  data_t     fill_data,
    input  logic      rom_cs,
    input  rom_addr_t rom_addr,
    output logic      rom_ok,
    output data_t     rom_data
);

    logic      valid_q, valid_d;
    rom_addr_t tag_q,   tag_d;
    data_t     data_q,  data_d;

    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        data_d  = data_q;
        if (fill) begin
            valid_d = 1'b1;
            tag_d   = fill_tag;
            data_d  = fill_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            tag_q   <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            tag_q   <= tag_d;
            data_q  <= data_d;
        end
    end

    assign rom_ok   = rom_cs & valid_q & (tag_q == rom_addr);
    assign rom_data = data_q;

endmodule

// File: rtl/jts16_mem_bridge.sv
// Purpose : arbitrates CPU ROM/work-RAM/VRAM accesses onto one SDRAM port, ROM reads through a one-entry cache.
// Latency : ROM hit 0 cycles; miss or RAM/VRAM = 1 + ack wait + rdy wait + 1 cycles.
// Backpressure: sdram_req held until sdram_ack; ram_ok held while the originating cs and address stay put.
// Ports   : clk/rst; CPU side rom_cs/rom_addr, ram_cs/vram_cs/cpu_addr/cpu_dout/UDSWn/LDSWn,
//           rom_data/rom_ok, ram_data/ram_ok; SDRAM side through the sdram master modport.
module jts16_mem_bridge
    import jts16_mem_bridge_pkg::*;
#(
    parameter sdram_addr_t ROM_OFFSET  = ROM_OFFSET_DEF,
    parameter sdram_addr_t RAM_OFFSET  = RAM_OFFSET_DEF,
    parameter sdram_addr_t VRAM_OFFSET = VRAM_OFFSET_DEF
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      rom_cs,
    input  rom_addr_t rom_addr,
    input  logic      ram_cs,
    input  logic      vram_cs,
    input  cpu_addr_t cpu_addr,
    input  data_t     cpu_dout,
    input  logic      UDSWn,
    input  logic      LDSWn,
    output data_t     rom_data,
    output data_t     ram_data,
    output logic      rom_ok,
    output logic      ram_ok,
    jts16_mem_bridge_if.master sdram
);

    state_t      state_q,    state_d;
    src_t        src_q,      src_d;
    sdram_addr_t addr_q,     addr_d;
    logic        we_q,       we_d;
    logic [1:0]  dsn_q,      dsn_d;
    data_t       din_q,      din_d;
    rom_addr_t   rom_addr_q, rom_addr_d;
    cpu_addr_t   cpu_addr_q, cpu_addr_d;
    logic        drop_q,     drop_d;
    data_t       ram_data_q, ram_data_d;

    logic rom_hit;
    logic cache_fill;
    logic orig_cs;

    jts16_rom_cache u_cache (
        .clk       (clk),
        .rst       (rst),
        .fill      (cache_fill),
        .fill_tag  (rom_addr_q),
        .fill_data (sdram.sdram_dout),
        .rom_cs    (rom_cs),
        .rom_addr  (rom_addr),
        .rom_ok    (rom_hit),
        .rom_data  (rom_data)
    );

    // Chip select of whichever requester launched the current transaction.
    always_comb begin
        orig_cs = rom_cs;
        case (src_q)
            SRC_RAM:  orig_cs = ram_cs;
            SRC_VRAM: orig_cs = vram_cs;
            default:  orig_cs = rom_cs;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        src_d      = src_q;
        addr_d     = addr_q;
        we_d       = we_q;
        dsn_d      = dsn_q;
        din_d      = din_q;
        rom_addr_d = rom_addr_q;
        cpu_addr_d = cpu_addr_q;
        drop_d     = drop_q;
        ram_data_d = ram_data_q;
        cache_fill = 1'b0;

        case (state_q)
            IDLE: begin
                // RAM beats VRAM beats ROM; a ROM hit needs no SDRAM cycle.
                if (ram_cs || vram_cs) begin
                    src_d      = ram_cs ? SRC_RAM : SRC_VRAM;
                    addr_d     = sd_addr(ram_cs ? RAM_OFFSET : VRAM_OFFSET, SD_AW'(cpu_addr));
                    we_d       = ~(UDSWn & LDSWn);
                    dsn_d      = (UDSWn & LDSWn) ? 2'b11 : {UDSWn, LDSWn};
                    din_d      = cpu_dout;
                    cpu_addr_d = cpu_addr;
                    drop_d     = 1'b0;
                    state_d    = REQ;
                end else if (rom_cs && !rom_hit) begin
                    src_d      = SRC_ROM;
                    addr_d     = sd_addr(ROM_OFFSET, SD_AW'(rom_addr));
                    we_d       = 1'b0;
                    dsn_d      = 2'b11;
                    rom_addr_d = rom_addr;
                    drop_d     = 1'b0;
                    state_d    = REQ;
                end
            end
            REQ: begin
                // A dropped cs never aborts the SDRAM cycle, it only suppresses ram_ok.
                if (!orig_cs) drop_d = 1'b1;
                if (sdram.sdram_ack) state_d = WAIT;
            end
            WAIT: begin
                if (!orig_cs) drop_d = 1'b1;
                if (sdram.sdram_rdy) begin
                    state_d = DONE;
                    if (src_q == SRC_ROM) begin
                        cache_fill = 1'b1;
                    end else if (!we_q) begin
                        ram_data_d = sdram.sdram_dout;
                    end
                end
            end
            DONE: begin
                // ROM answers from the cache, so it leaves at once; RAM/VRAM holds
                // ram_ok until cs falls or the CPU moves to another address.
                if (src_q == SRC_ROM || drop_q || !orig_cs || (cpu_addr != cpu_addr_q)) begin
                    state_d = IDLE;
                    we_d    = 1'b0;
                    dsn_d   = 2'b11;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            src_q      <= SRC_ROM;
            addr_q     <= '0;
            we_q       <= 1'b0;
            dsn_q      <= 2'b11;
            din_q      <= '0;
            rom_addr_q <= '0;
            cpu_addr_q <= '0;
            drop_q     <= 1'b0;
            ram_data_q <= 16'hffff;
        end else begin
            state_q    <= state_d;
            src_q      <= src_d;
            addr_q     <= addr_d;
            we_q       <= we_d;
            dsn_q      <= dsn_d;
            din_q      <= din_d;
            rom_addr_q <= rom_addr_d;
            cpu_addr_q <= cpu_addr_d;
            drop_q     <= drop_d;
            ram_data_q <= ram_data_d;
        end
    end

    assign sdram.sdram_req  = (state_q == REQ);
    assign sdram.sdram_addr = addr_q;
    assign sdram.sdram_we   = we_q;
    assign sdram.sdram_dsn  = dsn_q;
    assign sdram.sdram_din  = din_q;

    assign rom_ok   = rom_hit;
    assign ram_data = ram_data_q;
    // Registered-address compare drops ram_ok in the very cycle the CPU address moves.
    assign ram_ok   = (state_q == DONE) && (src_q != SRC_ROM) && !drop_q && orig_cs
                      && (cpu_addr == cpu_addr_q);

endmodule

// File: tb/tb_jts16_mem_bridge.sv
// Purpose : directed self-checking bench for jts16_mem_bridge with hand-computed expectations.
// Latency : n/a.
// Backpressure: the bench plays the SDRAM controller, pulsing ack/rdy after chosen delays.
module tb_jts16_mem_bridge;
    import jts16_mem_bridge_pkg::*;

    logic      clk = 1'b0;
    logic      rst;
    logic      rom_cs, ram_cs, vram_cs;
    rom_addr_t rom_addr;
    cpu_addr_t cpu_addr;
    data_t     cpu_dout;
    logic      UDSWn, LDSWn;
    data_t     rom_data, ram_data;
    logic      rom_ok, ram_ok;

    int checks = 0;
    int errors = 0;

    jts16_mem_bridge_if sd ();

    jts16_mem_bridge dut (
        .clk      (clk),
        .rst      (rst),
        .rom_cs   (rom_cs),
        .rom_addr (rom_addr),
        .ram_cs   (ram_cs),
        .vram_cs  (vram_cs),
        .cpu_addr (cpu_addr),
        .cpu_dout (cpu_dout),
        .UDSWn    (UDSWn),
        .LDSWn    (LDSWn),
        .rom_data (rom_data),
        .ram_data (ram_data),
        .rom_ok   (rom_ok),
        .ram_ok   (ram_ok),
        .sdram    (sd.master)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called with the DUT in REQ; returns with the DUT in DONE.
    task automatic serve(input data_t data, input int ack_wait, input int rdy_wait);
        repeat (ack_wait) tick();
        check("req_before_ack", 32'(sd.sdram_req), 32'd1);
        sd.sdram_ack = 1'b1;
        tick();
        sd.sdram_ack = 1'b0;
        repeat (rdy_wait) tick();
        sd.sdram_rdy  = 1'b1;
        sd.sdram_dout = data;
        tick();
        sd.sdram_rdy  = 1'b0;
        sd.sdram_dout = 16'h0000;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        rst = 1'b1;
        rom_cs = 1'b0; ram_cs = 1'b0; vram_cs = 1'b0;
        rom_addr = '0; cpu_addr = '0; cpu_dout = '0;
        UDSWn = 1'b1; LDSWn = 1'b1;
        sd.sdram_ack = 1'b0; sd.sdram_rdy = 1'b0; sd.sdram_dout = '0;
        tick(); tick();

        // Reset state
        check("rst_state",   32'(dut.state_q),        32'(IDLE));
        check("rst_valid",   32'(dut.u_cache.valid_q), 32'd0);
        check("rst_req",     32'(sd.sdram_req),       32'd0);
        check("rst_we",      32'(sd.sdram_we),        32'd0);
        check("rst_dsn",     32'(sd.sdram_dsn),       32'd3);
        check("rst_ram_ok",  32'(ram_ok),             32'd0);
        check("rst_rom_ok",  32'(rom_ok),             32'd0);
        check("rst_ramdata", 32'(ram_data),           32'h0000ffff);
        rst = 1'b0;
        tick();

        // ROM miss at 17'h00100, rdy three cycles after ack
        rom_cs = 1'b1; rom_addr = 17'h00100;
        #1;
        check("miss_no_ok", 32'(rom_ok), 32'd0);
        tick();
        check("miss_addr", 32'(sd.sdram_addr), 32'h000100);
        check("miss_we",   32'(sd.sdram_we),   32'd0);
        serve(16'h4E75, 1, 2);
        check("miss_ok",   32'(rom_ok),   32'd1);
        check("miss_data", 32'(rom_data), 32'h4E75);
        tick();
        rom_cs = 1'b0;
        tick();

        // Repeat read hits with no SDRAM request
        rom_cs = 1'b1; rom_addr = 17'h00100;
        #1;
        check("hit_ok",   32'(rom_ok),   32'd1);
        check("hit_data", 32'(rom_data), 32'h4E75);
        tick();
        check("hit_noreq", 32'(sd.sdram_req), 32'd0);
        rom_cs = 1'b0;

        // VRAM low-byte write
        vram_cs = 1'b1; cpu_addr = 13'h0010; LDSWn = 1'b0; UDSWn = 1'b1; cpu_dout = 16'h00AB;
        tick();
        check("vw_addr", 32'(sd.sdram_addr), 32'h104010);
        check("vw_we",   32'(sd.sdram_we),   32'd1);
        check("vw_dsn",  32'(sd.sdram_dsn),  32'd2);
        check("vw_din",  32'(sd.sdram_din),  32'h00AB);
        serve(16'h0000, 1, 1);
        check("vw_ok", 32'(ram_ok), 32'd1);
        tick();
        check("vw_ok_hold", 32'(ram_ok), 32'd1);
        vram_cs = 1'b0;
        #1;
        check("vw_ok_drop", 32'(ram_ok), 32'd0);
        tick();
        check("vw_idle_we",  32'(sd.sdram_we), 32'd0);
        check("vw_ramdata",  32'(ram_data),    32'h0000ffff);
        LDSWn = 1'b1;
        rom_cs = 1'b1; rom_addr = 17'h00100;
        #1;
        check("vw_cache_kept", 32'(rom_ok), 32'd1);
        rom_cs = 1'b0;
        tick();

        // RAM read and ROM miss in the same cycle: RAM first
        ram_cs = 1'b1; rom_cs = 1'b1; rom_addr = 17'h00200; cpu_addr = 13'h0123;
        tick();
        check("pri_addr", 32'(sd.sdram_addr), 32'h100123);
        check("pri_dsn",  32'(sd.sdram_dsn),  32'd3);
        serve(16'h1234, 0, 0);
        check("pri_ram_ok",   32'(ram_ok),   32'd1);
        check("pri_ram_data", 32'(ram_data), 32'h1234);
        check("pri_rom_wait", 32'(rom_ok),   32'd0);
        ram_cs = 1'b0;
        tick();
        tick();
        check("pri_rom_addr", 32'(sd.sdram_addr), 32'h000200);
        serve(16'hBEEF, 0, 1);
        check("pri_rom_ok",   32'(rom_ok),   32'd1);
        check("pri_rom_data", 32'(rom_data), 32'hBEEF);
        rom_cs = 1'b0;
        tick();

        // Address change with cs held: ok drops at once, new access follows
        ram_cs = 1'b1; cpu_addr = 13'h0040;
        tick();
        serve(16'h5555, 0, 0);
        check("ac_ok1", 32'(ram_ok), 32'd1);
        cpu_addr = 13'h0041;
        #1;
        check("ac_drop", 32'(ram_ok), 32'd0);
        tick();
        tick();
        check("ac_addr", 32'(sd.sdram_addr), 32'h100041);
        serve(16'h6666, 0, 0);
        check("ac_ok2",   32'(ram_ok),   32'd1);
        check("ac_data2", 32'(ram_data), 32'h6666);
        ram_cs = 1'b0;
        tick();

        // RAM cs dropped in WAIT then re-raised: completes silently
        ram_cs = 1'b1; cpu_addr = 13'h0050;
        tick();
        sd.sdram_ack = 1'b1;
        tick();
        sd.sdram_ack = 1'b0;
        ram_cs = 1'b0;
        tick();
        ram_cs = 1'b1;
        sd.sdram_rdy = 1'b1; sd.sdram_dout = 16'h7777;
        tick();
        sd.sdram_rdy = 1'b0;
        check("drop_no_ok", 32'(ram_ok), 32'd0);
        ram_cs = 1'b0;
        tick();

        // ROM cs dropped during WAIT: cache still filled
        rom_cs = 1'b1; rom_addr = 17'h00300;
        tick();
        sd.sdram_ack = 1'b1;
        tick();
        sd.sdram_ack = 1'b0;
        rom_cs = 1'b0;
        tick();
        sd.sdram_rdy = 1'b1; sd.sdram_dout = 16'hCAFE;
        tick();
        sd.sdram_rdy = 1'b0;
        check("rdrop_no_ok", 32'(rom_ok), 32'd0);
        tick();
        rom_cs = 1'b1; rom_addr = 17'h00300;
        #1;
        check("rdrop_hit",  32'(rom_ok),   32'd1);
        check("rdrop_data", 32'(rom_data), 32'hCAFE);
        tick();
        check("rdrop_noreq", 32'(sd.sdram_req), 32'd0);
        rom_cs = 1'b0;

        // Reset in WAIT, then a late rdy
        rom_cs = 1'b1; rom_addr = 17'h00400;
        tick();
        sd.sdram_ack = 1'b1;
        tick();
        sd.sdram_ack = 1'b0;
        check("mr_in_wait", 32'(dut.state_q), 32'(WAIT));
        rst = 1'b1; rom_cs = 1'b0;
        tick();
        rst = 1'b0;
        check("mr_state", 32'(dut.state_q), 32'(IDLE));
        sd.sdram_rdy = 1'b1; sd.sdram_dout = 16'h1111;
        tick();
        sd.sdram_rdy = 1'b0;
        check("mr_late_state", 32'(dut.state_q),         32'(IDLE));
        check("mr_valid",      32'(dut.u_cache.valid_q), 32'd0);
        check("mr_ram_ok",     32'(ram_ok),              32'd0);
        rom_cs = 1'b1; rom_addr = 17'h00100;
        #1;
        check("mr_rom_ok", 32'(rom_ok), 32'd0);
        rom_cs = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/jts16_mem_bridge.md
JTS16_MEM_BRIDGE -- requirements
Module: jts16_mem_bridge

Interface
REQ-001 SHALL have parameter ROM_OFFSET, default 22'h00_0000, SDRAM word base of main-CPU ROM.
REQ-002 SHALL have parameter RAM_OFFSET, default 22'h10_0000, SDRAM word base of work RAM.
REQ-003 SHALL have parameter VRAM_OFFSET, default 22'h10_4000, SDRAM word base of tile VRAM.
REQ-004 clk  in  1  system clock; the only clock.
REQ-005 rst  in  1  reset; synchronous, active-high.
REQ-006 rom_cs  in  1  ROM read request.
REQ-007 rom_addr  in  17  ROM word address.
REQ-008 ram_cs, vram_cs  in  1 each  work-RAM / VRAM request.
REQ-009 cpu_addr  in  13  RAM/VRAM word address.
REQ-010 cpu_dout  in  16  write data.
REQ-011 UDSWn, LDSWn  in  1 each  byte write strobes, low active; both high = read.
REQ-012 rom_data, ram_data  out  16  read data.
REQ-013 rom_ok, ram_ok  out  1 each  data valid / write done.
REQ-014 sdram_req  out  1  SDRAM request, held until sdram_ack.
REQ-015 sdram_addr  out  22  SDRAM word address.
REQ-016 sdram_we  out  1  write request.
REQ-017 sdram_dsn  out  2  byte mask {UDSWn,LDSWn}, write only.
REQ-018 sdram_din  out  16  write data.
REQ-019 sdram_ack  in  1  request accepted, one-cycle pulse.
REQ-020 sdram_rdy  in  1  read data valid / write complete, one-cycle pulse.
REQ-021 sdram_dout  in  16  read data.

Function
REQ-022 States: IDLE, REQ, WAIT, DONE.
REQ-023 ROM path: one-entry cache (tag 17 bits, data 16 bits, valid bit).
REQ-024 rom_ok SHALL equal rom_cs & valid & (tag==rom_addr), combinational; rom_data = cached data.
REQ-025 IDLE, rom_cs, cache miss, no RAM/VRAM request -> REQ; sdram_addr = ROM_OFFSET + rom_addr, sdram_we=0.
REQ-026 IDLE, ram_cs or vram_cs -> REQ; sdram_addr = RAM_OFFSET/VRAM_OFFSET + cpu_addr; sdram_we = ~(UDSWn & LDSWn).
REQ-027 Priority: ram_cs, then vram_cs, then rom_cs, when several are asserted in the same cycle.
REQ-028 REQ: sdram_req=1, address/we/dsn/din held stable; sdram_ack -> WAIT.
REQ-029 WAIT: sdram_rdy -> DONE; a ROM read loads tag, data and valid=1 on that edge; a RAM read latches ram_data.
REQ-030 DONE: ram_ok=1 while the originating cs stays high; cs low -> IDLE on the next edge, ram_ok=0.
REQ-031 ROM transaction: DONE -> IDLE immediately; rom_ok comes from the REQ-024 compare, one cycle after sdram_rdy.
REQ-032 A cs deasserting in REQ/WAIT SHALL NOT abort the SDRAM transaction; it completes, ROM data still fills the cache, and no ram_ok is produced.
REQ-033 An address change with cs still high SHALL be treated as a new access; ram_ok drops in the same cycle via a registered-address compare.
REQ-034 RAM/VRAM writes SHALL NOT touch the ROM cache.
REQ-035 Minimum latency: ROM hit 0 cycles after cs; miss or RAM access = 1 + ack wait + rdy wait + 1.
REQ-036 sdram_addr SHALL be computed with 22-bit modular addition; overflow wraps and is not flagged.

Reset
REQ-037 rst SHALL set state=IDLE, valid=0, sdram_req=0, sdram_we=0, sdram_dsn=2'b11, ram_ok=0, rom_ok=0, ram_data=16'hffff.
REQ-038 rst asserted mid-transaction SHALL return to IDLE next edge; a late sdram_rdy is ignored.

Structure
REQ-039 State encoding and default offsets SHALL live in the shared jts16 package/include.
REQ-040 A single sub-module, jts16_rom_cache (tag/data/valid, hit compare), SHALL hold the ROM path; the FSM is in the top.

Verification
REQ-041 ROM read 17'h00100, SDRAM returns 16'h4E75 after ack+3 cycles -> sdram_addr 22'h000100; rom_ok=1 with 16'h4E75 one cycle after rdy.
REQ-042 Repeat read 17'h00100 -> rom_ok=1 in the same cycle as rom_cs, no sdram_req.
REQ-043 vram_cs, cpu_addr 13'h0010, LDSWn=0, UDSWn=1, data 16'h00AB -> sdram_addr 22'h104010, we=1, dsn=2'b10; ram_ok after rdy until cs low.
REQ-044 rom_cs and ram_cs high in the same cycle -> RAM served first, then the ROM miss.
REQ-045 rom_cs dropped during WAIT -> transaction completes, cache filled; later read of the same address hits with no sdram_req.
REQ-046 rst pulsed in WAIT, then rdy -> state IDLE, valid=0, no ok asserted.
